bin_to_bcd_sequencer: RTL and testbench
=======================================

Name: bin_to_bcd_sequencer

Overview:
- Iterative shift-add-3 (double-dabble) converter that turns a binary count into packed BCD digits for the seven-segment display driver.
- Sits directly upstream of the seven-segment scan/decoder stage and feeds it one 4-bit BCD nibble per display digit.
- Holds each result stable between conversions so the display multiplexer can scan it at its own rate.
- Uses a start/busy/done handshake with an overflow flag and an optional leading-zero blank mask.

Parameters:
- BIN_W, 27: width of the binary input.
- DIGITS, 8: number of BCD digits produced; matches the 8 display anodes.

Ports:
- clck  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  conversion request; sampled only in IDLE.
- bin_in  input  BIN_W  binary value; captured on the accepted start edge.
- busy  output  1  conversion in progress.
- done  output  1  one-cycle pulse; result valid.
- bcd_out  output  4*DIGITS  packed BCD; digit 0 (least significant) in bits [3:0].
- overflow  output  1  captured input exceeded 10^DIGITS-1.
- blank  output  DIGITS  per-digit leading-zero blank mask.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, busy=0, done=0, bcd_out=0, overflow=0.
  - blank resets to the mask for value 0 (see Optional Feature).
  - Reset mid-conversion abandons the conversion; no done follows reset release.
- States and transitions:
  - IDLE -> SHIFT on start=1.
  - SHIFT -> SHIFT until BIN_W shifts are complete.
  - SHIFT -> DONE after the final shift.
  - DONE -> IDLE unconditionally.
- Edge k, IDLE with start=1:
  - Load bin_in into the shift register and clear the BCD work register; bit counter=0.
  - Compute ovf_pend = (bin_in > 10^DIGITS-1); busy=1.
- Edges k+1..k+BIN_W, SHIFT, one bit per cycle:
  - First add 3 to every work nibble >= 5.
  - Then shift {work, shift_reg} left by 1.
  - Edge k+BIN_W performs the last shift and moves to DONE.
- Edge k+BIN_W+1, DONE:
  - bcd_out <= ovf_pend ? all nibbles 4'h9 (saturate) : work.
  - overflow <= ovf_pend; done=1; busy=0; state -> IDLE.
- Latency: done is high in the cycle starting BIN_W+1 edges after start was sampled (28 cycles for defaults).
- done is exactly one cycle wide. busy is high from edge k to edge k+BIN_W+1, and busy and done are never high together.
- start while busy is ignored, and a bin_in change while busy has no effect.
- start high in the done cycle is accepted (state is already IDLE), so back-to-back conversions are allowed.
- bcd_out, overflow and blank change only on the DONE edge or on reset; they are stable otherwise.
- The work register is 4*DIGITS bits. Inputs <= 10^DIGITS-1 never lose bits off the top; inputs above that are flagged and saturated.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined:
  - blank[i]=1 when digit i and every higher digit are 0, for i >= 1.
  - blank[0] is always 0, so "0" still displays.
  - blank is updated together with bcd_out.
  - Reset value is all ones except bit 0 (8'hFE for defaults).
  - An overflow result gives blank=0.
- Undefined: blank is tied to all zeros at all times, including during reset.

Test Plan:
- Reset, then start with bin_in=0:
  - busy rises next edge; done pulses 28 cycles after the start edge.
  - bcd_out=32'h00000000, overflow=0, blank=8'hFE (feature on) or 8'h00 (feature off).
- bin_in=12345678 -> bcd_out=32'h12345678, blank=8'h00, overflow=0. bin_in=905 -> bcd_out=32'h00000905, blank=8'hF8 (feature on).
- bin_in=99999999 -> bcd_out=32'h99999999, overflow=0. bin_in=100000000 -> bcd_out=32'h99999999, overflow=1, blank=8'h00.
- start with bin_in=42, then hold start=1 and change bin_in to 7 during busy:
  - Only one done is produced while busy, with bcd_out=32'h00000042.
  - start held into the done cycle launches a second conversion of 7, giving 32'h00000007 28 cycles later.
- Drive reset=0 ten cycles into a conversion of 555:
  - busy, done and bcd_out go to 0 immediately, without waiting for a clck edge.
  - After release, no done pulse until a new start.
- Two conversions separated by idle cycles: bcd_out holds the first result unchanged through the idle gap and through the second conversion until its DONE edge.

Source files
------------

// File: rtl/bin_to_bcd_sequencer.sv
// bin_to_bcd_sequencer: iterative shift-add-3 (double-dabble) converter that
// turns a BIN_W-bit binary count into DIGITS packed BCD nibbles for the
// seven-segment scan stage. The result is held between conversions.
// Optional feature: define LEADING_ZERO_BLANK_EN to drive the per-digit
// leading-zero blank mask. When it is undefined, blank is tied to zero.

// Per-digit adjust step: add 3 to any nibble >= 5 ahead of the shift.
module bin_to_bcd_digit (
    input  logic [3:0] d,
    output logic [3:0] q
);
    assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module bin_to_bcd_sequencer #(
    parameter int BIN_W  = 27,
    parameter int DIGITS = 8
) (
    input  logic                clck,
    input  logic                reset,
    input  logic                start,
    input  logic [BIN_W-1:0]    bin_in,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic                overflow,
    output logic [DIGITS-1:0]   blank
);
    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

    localparam longint unsigned MAX_VAL = pow10(DIGITS) - 64'd1;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                    state;
    logic [CNT_W-1:0]          cnt;
    logic [BIN_W-1:0]          shift_reg;
    logic [DIGITS-1:0][3:0]    work;
    logic [DIGITS-1:0][3:0]    work_adj;
    logic [4*DIGITS:0]         work_shl;
    logic                      ovf_pend;

    // one adjust cell per BCD digit
    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        bin_to_bcd_digit u_dig (
            .d (work[g]),
            .q (work_adj[g])
        );
    end

    // Adjusted work register with the next binary bit shifted in. The bit
    // falling off the top can only be set for out-of-range inputs; it is
    // folded into ovf_pend as a safety net.
    assign work_shl = {work_adj, shift_reg[BIN_W-1]};

    // Conversion sequencer: capture on start, BIN_W dabble steps, then publish.
    always_ff @(posedge clck or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            bcd_out   <= '0;
            overflow  <= 1'b0;
            cnt       <= '0;
            shift_reg <= '0;
            work      <= '0;
            ovf_pend  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_reg <= bin_in;
                        work      <= '0;
                        cnt       <= '0;
                        ovf_pend  <= (64'(bin_in) > MAX_VAL);
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    work      <= work_shl[4*DIGITS-1:0];
                    shift_reg <= {shift_reg[BIN_W-2:0], 1'b0};
                    ovf_pend  <= ovf_pend | work_shl[4*DIGITS];
                    cnt       <= cnt + 1'b1;
                    if (cnt == CNT_W'(BIN_W - 1)) state <= DONE;
                end
                DONE: begin
                    bcd_out  <= ovf_pend ? {DIGITS{4'h9}} : work;
                    overflow <= ovf_pend;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] blank_nxt;
    logic              zero_above;

    // Digit i blanks when it and every higher digit are zero; digit 0 never blanks.
    always_comb begin
        blank_nxt  = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above   = zero_above & (work[i] == 4'd0);
            blank_nxt[i] = zero_above;
        end
    end

    // Blank mask published alongside bcd_out; saturated results show all digits.
    always_ff @(posedge clck or negedge reset) begin
        if (!reset) begin
            blank <= {{(DIGITS-1){1'b1}}, 1'b0};
        end else if (state == DONE) begin
            blank <= ovf_pend ? '0 : blank_nxt;
        end
    end
`else
    assign blank = '0;
`endif

endmodule

// File: tb/tb_bin_to_bcd_sequencer.sv
// Self-checking bench for bin_to_bcd_sequencer: directed and random conversions
// against a decimal-arithmetic reference model.
module tb_bin_to_bcd_sequencer;
    localparam int BIN_W  = 27;
    localparam int DIGITS = 8;
    localparam longint unsigned MAX_VAL = 64'd99999999;

    logic                clck = 1'b0;
    logic                reset = 1'b0;
    logic                start = 1'b0;
    logic [BIN_W-1:0]    bin_in = '0;
    logic                busy, done, overflow;
    logic [4*DIGITS-1:0] bcd_out;
    logic [DIGITS-1:0]   blank;

    int errors = 0;
    int checks = 0;
    logic [31:0] prev = '0;

    always #5 clck = ~clck;

    bin_to_bcd_sequencer #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clck     (clck),
        .reset    (reset),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd_out),
        .overflow (overflow),
        .blank    (blank)
    );

    // reference: decimal digits by repeated division, saturate out-of-range
    function automatic logic [31:0] ref_bcd(input longint unsigned v);
        logic [31:0] r;
        longint unsigned t;
        if (v > MAX_VAL) return {8{4'h9}};
        t = v;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // digit i (i>=1) and all above are zero exactly when v < 10^i
    function automatic logic [7:0] ref_blank(input longint unsigned v);
        logic [7:0] m;
        longint unsigned p;
        m = '0;
`ifdef LEADING_ZERO_BLANK_EN
        if (v <= MAX_VAL) begin
            p = 1;
            for (int i = 1; i < DIGITS; i++) begin
                p = p * 10;
                m[i] = (v < p);
            end
        end
`endif
        return m;
    endfunction

    function automatic logic [7:0] rst_blank();
`ifdef LEADING_ZERO_BLANK_EN
        return 8'hFE;
`else
        return 8'h00;
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clck);
        #1;
    endtask

    // called just after the start edge; returns edges until done appears
    task automatic wait_done(input logic [31:0] hold, output int lat);
        logic stable, busy_ok;
        lat = 0;
        stable = 1'b1;
        busy_ok = 1'b1;
        while (lat < 40 && done !== 1'b1) begin
            tick();
            lat++;
            if (done !== 1'b1) begin
                if (bcd_out !== hold) stable = 1'b0;
                if (busy !== 1'b1) busy_ok = 1'b0;
            end
        end
        chk("latency", 64'(lat), 64'(BIN_W + 1));
        chk("hold_while_busy", stable, 1'b1);
        chk("busy_held", busy_ok, 1'b1);
    endtask

    task automatic chk_result(input longint unsigned v);
        chk("bcd_out", bcd_out, ref_bcd(v));
        chk("overflow", overflow, v > MAX_VAL);
        chk("blank", blank, ref_blank(v));
        chk("busy_in_done", busy, 1'b0);
    endtask

    task automatic convert(input longint unsigned v);
        int lat;
        start  = 1'b1;
        bin_in = BIN_W'(v);
        tick();
        chk("busy_rise", busy, 1'b1);
        chk("no_done_at_start", done, 1'b0);
        start  = 1'b0;
        bin_in = BIN_W'($urandom);
        wait_done(prev, lat);
        chk_result(v);
        prev = ref_bcd(v);
        tick();
        chk("done_one_cycle", done, 1'b0);
    endtask

    task automatic idle_gap(input int n);
        logic ok;
        ok = 1'b1;
        repeat (n) begin
            tick();
            if (bcd_out !== prev || done !== 1'b0 || busy !== 1'b0) ok = 1'b0;
        end
        chk("idle_hold", ok, 1'b1);
    endtask

    initial begin
        int lat;
        logic saw_done;
        longint unsigned v;
        int sel;

        // reset state
        #3;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_bcd", bcd_out, 32'h0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_blank", blank, rst_blank());
        tick();
        tick();
        reset = 1'b1;
        tick();

        // directed values
        convert(0);
        convert(12345678);
        convert(905);
        idle_gap(3);
        convert(99999999);
        convert(100000000);
        convert(64'(2**BIN_W - 1));

        // start held through busy with bin_in changing; second conversion back-to-back
        start  = 1'b1;
        bin_in = BIN_W'(42);
        tick();
        chk("hold_busy_rise", busy, 1'b1);
        bin_in = BIN_W'(7);
        wait_done(prev, lat);
        chk_result(42);
        prev = ref_bcd(42);
        tick();
        chk("b2b_busy", busy, 1'b1);
        chk("b2b_done_low", done, 1'b0);
        start = 1'b0;
        wait_done(prev, lat);
        chk_result(7);
        prev = ref_bcd(7);
        tick();

        // asynchronous reset ten cycles into a conversion
        start  = 1'b1;
        bin_in = BIN_W'(555);
        tick();
        start = 1'b0;
        repeat (10) tick();
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_bcd", bcd_out, 32'h0);
        chk("mid_rst_ovf", overflow, 1'b0);
        chk("mid_rst_blank", blank, rst_blank());
        repeat (2) tick();
        reset = 1'b1;
        prev = '0;
        saw_done = 1'b0;
        repeat (40) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
        end
        chk("no_done_after_rst", saw_done, 1'b0);
        chk("bcd_after_rst", bcd_out, 32'h0);

        // random conversions separated by idle gaps
        for (int n = 0; n < 12; n++) begin
            sel = int'($urandom_range(0, 3));
            if (sel == 0)      v = longint'($urandom_range(0, 999));
            else if (sel == 1) v = 64'd99999990 + longint'($urandom_range(0, 20));
            else               v = longint'($urandom_range(0, 2**BIN_W - 1));
            convert(v);
            idle_gap(int'($urandom_range(1, 5)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
